// File: rtl/spi_flash_responder.sv
// Mode-0 SPI flash target. It answers single read (0x03) and quad-output
// fast read (0x6B) from a synchronous byte-wide memory port. All SPI pins
// are oversampled in the clk domain, so SCK is never used as a clock.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | CS high or just reset; pads not driven
// CMD    | shifting in the 8-bit command, MSB first
// ADDR   | shifting in ADDR_BITS of address, MSB first
// DUMMY  | counting dummy SCK cycles ahead of quad data
// DATA   | streaming bytes out on SCK falls until deselect
// IGNORE | unsupported command; wait for deselect
module spi_flash_responder #(
  parameter int ADDR_BITS    = 16,
  parameter int DUMMY_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 spi_clk_in,
  input  logic                 spi_select_in,
  input  logic [3:0]           spi_data_in,
  output logic [3:0]           spi_data_out,
  output logic [3:0]           spi_data_oe,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_req,
  input  logic [7:0]           mem_rdata,
  output logic                 active,
  output logic                 bad_cmd
);

  // bit_cnt serves both the 8-bit command and the address, so size it for the larger
  localparam int BCW = (ADDR_BITS > 8) ? $clog2(ADDR_BITS) : 3;
  localparam int CW  = (DUMMY_CYCLES > 1) ? $clog2(DUMMY_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, DATA, IGNORE
  } state_t;

  state_t state, state_next;

  logic sck_s1, sck_s2, sck_prev;
  logic cs_s1, cs_s2;
  logic mosi_s1, mosi_s2;
  logic sck_rise, sck_fall;

  logic [7:0]           cmd_reg;
  logic [ADDR_BITS-2:0] addr_reg;
  logic [BCW-1:0]       bit_cnt;
  logic [CW-1:0]        dummy_cnt;
  logic                 dummy_done;
  logic [7:0]           shifter;
  logic [7:0]           prefetch;
  logic                 req_d;

  logic [7:0]           cmd_byte;
  logic [ADDR_BITS-1:0] addr_word;
  logic                 quad;
  logic                 cmd_ok, cmd_bad, addr_done, data_load, data_shift;

  // IO[3:1] are outputs only for the supported commands
  logic unused_io;
  assign unused_io = ^spi_data_in[3:1];

  assign sck_rise  = sck_s2 & ~sck_prev;
  assign sck_fall  = ~sck_s2 & sck_prev;
  assign cmd_byte  = {cmd_reg[6:0], mosi_s2};
  assign addr_word = {addr_reg, mosi_s2};
  assign quad      = (cmd_reg == 8'h6B);
  assign active    = (state != IDLE);

  // Two-flop synchronisers; the extra SCK flop provides edge detection.
  // CS resets to deselected so a reset never looks like a select.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sck_s1   <= 1'b0;
      sck_s2   <= 1'b0;
      sck_prev <= 1'b0;
      cs_s1    <= 1'b1;
      cs_s2    <= 1'b1;
      mosi_s1  <= 1'b0;
      mosi_s2  <= 1'b0;
    end else begin
      sck_s1   <= spi_clk_in;
      sck_s2   <= sck_s1;
      sck_prev <= sck_s2;
      cs_s1    <= spi_select_in;
      cs_s2    <= cs_s1;
      mosi_s1  <= spi_data_in[0];
      mosi_s2  <= mosi_s1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and per-clk action strobes; deselect overrides any SCK edge
  always_comb begin
    state_next = state;
    cmd_ok     = 1'b0;
    cmd_bad    = 1'b0;
    addr_done  = 1'b0;
    data_load  = 1'b0;
    data_shift = 1'b0;
    if (cs_s2) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: state_next = CMD;
        CMD: begin
          if (sck_rise && bit_cnt == '0) begin
            if (cmd_byte == 8'h6B || cmd_byte == 8'h03) begin
              cmd_ok     = 1'b1;
              state_next = ADDR;
            end else begin
              cmd_bad    = 1'b1;
              state_next = IGNORE;
            end
          end
        end
        ADDR: begin
          if (sck_rise && bit_cnt == '0) begin
            addr_done  = 1'b1;
            state_next = quad ? DUMMY : DATA;
          end
        end
        DUMMY: begin
          if (sck_fall && dummy_done) begin
            data_load  = 1'b1;
            state_next = DATA;
          end
        end
        DATA: begin
          if (sck_fall) begin
            if (bit_cnt == '0) data_load  = 1'b1;
            else               data_shift = 1'b1;
          end
        end
        IGNORE: state_next = IGNORE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath: command/address shifting, dummy count, prefetch and output shifter.
  // Entering DATA for 0x03 leaves bit_cnt at 0, so the first fall loads a byte.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cmd_reg      <= '0;
      addr_reg     <= '0;
      bit_cnt      <= '0;
      dummy_cnt    <= '0;
      dummy_done   <= 1'b0;
      shifter      <= '0;
      prefetch     <= '0;
      req_d        <= 1'b0;
      mem_addr     <= '0;
      mem_req      <= 1'b0;
      bad_cmd      <= 1'b0;
      spi_data_out <= '0;
      spi_data_oe  <= '0;
    end else begin
      mem_req <= 1'b0;
      bad_cmd <= 1'b0;
      req_d   <= mem_req;
      if (req_d) prefetch <= mem_rdata;
      if (cs_s2) begin
        spi_data_oe  <= '0;
        spi_data_out <= '0;
      end else begin
        case (state)
          IDLE: bit_cnt <= BCW'(7);
          CMD: begin
            if (sck_rise) begin
              cmd_reg <= cmd_byte;
              bad_cmd <= cmd_bad;
              if (cmd_ok)              bit_cnt <= BCW'(ADDR_BITS - 1);
              else if (bit_cnt != '0)  bit_cnt <= bit_cnt - 1'b1;
            end
          end
          ADDR: begin
            if (sck_rise) begin
              addr_reg <= addr_word[ADDR_BITS-2:0];
              if (addr_done) begin
                mem_addr   <= addr_word;
                mem_req    <= 1'b1;
                dummy_cnt  <= CW'(DUMMY_CYCLES - 1);
                dummy_done <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt - 1'b1;
              end
            end
          end
          DUMMY: begin
            if (sck_rise) begin
              if (dummy_cnt == '0) dummy_done <= 1'b1;
              else                 dummy_cnt  <= dummy_cnt - 1'b1;
            end
          end
          default: ;
        endcase
        if (data_load) begin
          mem_addr <= mem_addr + ADDR_BITS'(1);
          mem_req  <= 1'b1;
          if (quad) begin
            spi_data_out <= prefetch[7:4];
            shifter      <= {prefetch[3:0], 4'h0};
            spi_data_oe  <= 4'b1111;
            bit_cnt      <= BCW'(1);
          end else begin
            spi_data_out <= {2'b00, prefetch[7], 1'b0};
            shifter      <= {prefetch[6:0], 1'b0};
            spi_data_oe  <= 4'b0010;
            bit_cnt      <= BCW'(7);
          end
        end
        if (data_shift) begin
          bit_cnt <= bit_cnt - 1'b1;
          if (quad) begin
            spi_data_out <= shifter[7:4];
            shifter      <= {shifter[3:0], 4'h0};
          end else begin
            spi_data_out <= {2'b00, shifter[7], 1'b0};
            shifter      <= {shifter[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: expected pad values are queued as
// each read is issued and compared at every initiator sample point.
module tb_spi_flash_responder;

  localparam int AB = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          sck;
  logic          cs;
  logic [3:0]    din;
  logic [3:0]    dout;
  logic [3:0]    doe;
  logic [AB-1:0] mem_addr;
  logic          mem_req;
  logic [7:0]    mem_rdata = 8'h00;
  logic          active;
  logic          bad_cmd;

  always #5 clk = ~clk;

  spi_flash_responder #(.ADDR_BITS(AB), .DUMMY_CYCLES(8)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .spi_clk_in   (sck),
    .spi_select_in(cs),
    .spi_data_in  (din),
    .spi_data_out (dout),
    .spi_data_oe  (doe),
    .mem_addr     (mem_addr),
    .mem_req      (mem_req),
    .mem_rdata    (mem_rdata),
    .active       (active),
    .bad_cmd      (bad_cmd)
  );

  logic [7:0]    mem [0:65535];
  logic [3:0]    exp_q[$];
  logic [AB-1:0] req_log[$];
  int            bad_pulses = 0;
  logic [3:0]    oe_cmd_or;
  int            total = 0;
  int            bad = 0;

  // synchronous memory: data follows the strobe by one clk
  always @(posedge clk) if (mem_req) mem_rdata <= mem[mem_addr];

  always @(negedge clk) begin
    if (mem_req) req_log.push_back(mem_addr);
    if (bad_cmd) bad_pulses++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one SCK period: low 4 clk (fall first), sample pads, high 4 clk
  task automatic sck_bit(input logic mosi, output logic [3:0] io, output logic [3:0] oe);
    sck    = 1'b0;
    din[0] = mosi;
    repeat (4) @(negedge clk);
    io  = dout;
    oe  = doe;
    sck = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] val, input int n);
    logic [3:0] io, oe;
    for (int i = n - 1; i >= 0; i--) begin
      sck_bit(val[i], io, oe);
      oe_cmd_or = oe_cmd_or | oe;
    end
  endtask

  task automatic data_cycles(input int n, input logic [3:0] exp_oe, input string tag);
    logic [3:0] io, oe, e;
    for (int i = 0; i < n; i++) begin
      sck_bit(1'b0, io, oe);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL %s scoreboard empty observed=%0h", tag, io);
      end else begin
        e = exp_q.pop_front();
        check({tag, " data"}, io, e);
      end
      check({tag, " oe"}, oe, exp_oe);
    end
  endtask

  task automatic push_quad(input logic [7:0] b);
    exp_q.push_back(b[7:4]);
    exp_q.push_back(b[3:0]);
  endtask

  task automatic push_single(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back({2'b00, b[i], 1'b0});
  endtask

  task automatic start_cs();
    cs = 1'b0;
    oe_cmd_or = 4'h0;
    repeat (4) @(negedge clk);
  endtask

  task automatic end_cs();
    sck = 1'b0;
    cs  = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int base;
    int p0;
    rstn = 1'b0;
    sck  = 1'b0;
    cs   = 1'b1;
    din  = 4'h0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1234] = 8'hA5; mem[16'h1235] = 8'h3C;
    mem[16'h0010] = 8'h81;
    mem[16'hFFFF] = 8'h11; mem[16'h0000] = 8'h22;
    mem[16'h2000] = 8'hC7; mem[16'h2001] = 8'h5E;
    mem[16'h0300] = 8'h6D;
    mem[16'h4000] = 8'h9A; mem[16'h4001] = 8'hB2; mem[16'h4002] = 8'h47;

    repeat (3) @(negedge clk);
    check("reset oe", doe, 4'h0);
    check("reset out", dout, 4'h0);
    check("reset req", mem_req, 1'b0);
    check("reset addr", mem_addr, 16'h0000);
    check("reset active", active, 1'b0);
    check("reset bad_cmd", bad_cmd, 1'b0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // quad read 0x1234
    base = req_log.size();
    start_cs();
    send_bits(32'h6B, 8);
    send_bits(32'h1234, 16);
    push_quad(8'hA5);
    push_quad(8'h3C);
    send_bits(32'h0, 8);
    check("q1 oe before data", oe_cmd_or, 4'h0);
    data_cycles(2, 4'b1111, "q1");
    check("q1 reqs before 2nd byte", req_log.size() - base, 2);
    check("q1 req0", req_log[base], 16'h1234);
    check("q1 req1", req_log[base+1], 16'h1235);
    data_cycles(2, 4'b1111, "q1");
    check("q1 reqs total", req_log.size() - base, 3);
    check("q1 req2", req_log[base+2], 16'h1236);
    end_cs();
    check("q1 oe after cs", doe, 4'h0);

    // single read 0x0010
    start_cs();
    send_bits(32'h03, 8);
    send_bits(32'h0010, 16);
    push_single(8'h81);
    check("s1 oe before data", oe_cmd_or, 4'h0);
    data_cycles(8, 4'b0010, "s1");
    end_cs();

    // quad read with address wrap
    base = req_log.size();
    start_cs();
    send_bits(32'h6B, 8);
    send_bits(32'hFFFF, 16);
    push_quad(8'h11);
    push_quad(8'h22);
    send_bits(32'h0, 8);
    data_cycles(4, 4'b1111, "wrap");
    check("wrap req0", req_log[base], 16'hFFFF);
    check("wrap req1", req_log[base+1], 16'h0000);
    end_cs();

    // unsupported command
    base = req_log.size();
    p0   = bad_pulses;
    start_cs();
    send_bits(32'h9F, 8);
    send_bits(32'hA55A, 16);
    check("badcmd pulses", bad_pulses - p0, 1);
    check("badcmd oe", oe_cmd_or, 4'h0);
    check("badcmd no req", req_log.size() - base, 0);
    check("badcmd active", active, 1'b1);
    end_cs();
    check("badcmd active after cs", active, 1'b0);

    // deselect mid-read, then an immediate single read
    start_cs();
    send_bits(32'h6B, 8);
    send_bits(32'h2000, 16);
    push_quad(8'hC7);
    exp_q.push_back(4'h5);
    send_bits(32'h0, 8);
    data_cycles(3, 4'b1111, "abort");
    sck = 1'b0;
    cs  = 1'b1;
    repeat (3) @(negedge clk);
    check("abort oe latency", doe, 4'h0);
    repeat (3) @(negedge clk);
    start_cs();
    send_bits(32'h03, 8);
    send_bits(32'h0300, 16);
    push_single(8'h6D);
    data_cycles(8, 4'b0010, "after abort");
    end_cs();

    // reset during DATA
    start_cs();
    send_bits(32'h6B, 8);
    send_bits(32'h4000, 16);
    push_quad(8'h9A);
    send_bits(32'h0, 8);
    data_cycles(2, 4'b1111, "pre rst");
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("rst oe", doe, 4'h0);
    check("rst active", active, 1'b0);
    check("rst out", dout, 4'h0);
    end_cs();
    start_cs();
    send_bits(32'h6B, 8);
    send_bits(32'h4001, 16);
    push_quad(8'hB2);
    push_quad(8'h47);
    send_bits(32'h0, 8);
    data_cycles(4, 4'b1111, "post rst");
    end_cs();

    check("scoreboard drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
